// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding and widths for the CNN feature-map blocks
package cnn_pkg;
  localparam int CNN_SIZE_W = 8;
  localparam int CNN_ADDR_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} cnn_state_t;
endpackage

// File: rtl/ofmap_addr_gen.sv
// ofmap_addr_gen: raster row/col/linear write-address counters for a size x size map
module ofmap_addr_gen
  import cnn_pkg::*;
#(
  parameter int ADDR_W = CNN_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  step,
  input  logic [CNN_SIZE_W-1:0] size,
  output logic [ADDR_W-1:0]     addr,
  output logic                  last
);
  localparam logic [CNN_SIZE_W-1:0] ONE = CNN_SIZE_W'(1);
  logic [CNN_SIZE_W-1:0] size_q, row, col;
  logic [ADDR_W-1:0] size_sq;
  logic col_wrap;
  assign col_wrap = col == size_q - ONE;
  // size^2 is latched with size so the terminal compare stays a plain equality
  assign last = addr == size_sq - ADDR_W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q  <= '0;
      size_sq <= '0;
      row     <= '0;
      col     <= '0;
      addr    <= '0;
    end else if (clr) begin
      size_q  <= size;
      size_sq <= ADDR_W'(size) * ADDR_W'(size);
      row     <= '0;
      col     <= '0;
      addr    <= '0;
    end else if (step) begin
      col  <= col_wrap ? '0 : col + ONE;
      row  <= col_wrap ? row + ONE : row;
      addr <= addr + ADDR_W'(1);
    end
  end
endmodule

// File: rtl/cnn_ofmap_writer.sv
// cnn_ofmap_writer: streams output pixels into the feature-map buffer in raster order.
// Optional CNN_OFMAP_RELU_EN clamps negative pixels to zero before the write register.
module cnn_ofmap_writer
  import cnn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = CNN_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  enable,
  input  logic [CNN_SIZE_W-1:0] size,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  done
);
  cnn_state_t state;
  logic accept, clr, last, size_zero;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pix;
  assign in_ready  = state == RUN && enable;
  assign accept    = in_valid && in_ready;
  assign clr       = state == IDLE && start;
  assign busy      = state != IDLE;
  assign size_zero = size == '0;
`ifdef CNN_OFMAP_RELU_EN
  assign pix = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign pix = in_data;
`endif
  ofmap_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .step (accept),
    .size (size),
    .addr (addr),
    .last (last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      wr_en <= accept;
      done  <= 1'b0;
      if (accept) begin
        wr_addr <= addr;
        wr_data <= pix;
      end
      unique case (state)
        IDLE: if (start) begin
          state <= size_zero ? DONE : RUN;
          done  <= size_zero;
        end
        RUN: if (accept && last) begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_ofmap_writer.sv
// tb_cnn_ofmap_writer: scoreboard bench for cnn_ofmap_writer (honours CNN_OFMAP_RELU_EN)
module tb_cnn_ofmap_writer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, enable = 1'b0, in_valid = 1'b0;
  logic [7:0] size = '0;
  logic [15:0] in_data = '0, wr_addr, wr_data;
  logic in_ready, wr_en, busy, done;
  int checks = 0, errors = 0;
  logic [31:0] sb[$];
  int m = 0, msz = 0, maddr = 0, nwr = 0, last_addr = -1;
  logic acc;

  cnn_ofmap_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .size(size),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] d);
`ifdef CNN_OFMAP_RELU_EN
    return d[15] ? 16'h0 : d;
`else
    return d;
`endif
  endfunction

  task automatic tick(input logic st, input logic [7:0] sz, input logic en, input logic v,
                      input logic [15:0] d);
    int nm;
    logic [31:0] e;
    start = st; size = sz; enable = en; in_valid = v; in_data = d;
    #1;
    acc = m == 1 && en && v;
    check("in_ready", in_ready, m == 1 && en);
    nm = m;
    if (m == 0 && st) begin
      msz = sz; maddr = 0; nwr = 0;
      nm = sz == 0 ? 2 : 1;
    end else if (acc) begin
      sb.push_back({maddr[15:0], relu(d)});
      if (maddr == msz * msz - 1) nm = 2;
      maddr++;
    end else if (m == 2) nm = 0;
    @(posedge clk);
    #1;
    m = nm;
    check("wr_en", wr_en, acc);
    if (wr_en) begin
      nwr++;
      last_addr = wr_addr;
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        check("wr_addr", wr_addr, e[31:16]);
        check("wr_data", wr_data, e[15:0]);
      end
    end
    check("done", done, m == 2);
    check("busy", busy, m != 0);
  endtask

  task automatic run_map(input logic [7:0] sz, input int stall, input int busy_start,
                         input logic [15:0] fixed);
    int n;
    logic [15:0] d;
    tick(1'b1, sz, 1'b0, 1'b0, 16'h0);
    n = 0;
    while (m != 0 && n < 70000) begin
      d = fixed != 0 ? fixed : 16'($urandom);
      tick(busy_start != 0, busy_start != 0 ? 8'd14 : 8'd0,
           stall != 0 ? 1'($urandom_range(0, 3) != 0) : 1'b1,
           stall != 0 ? 1'($urandom_range(0, 2) != 0) : 1'b1, d);
      n++;
    end
    if (m != 0) begin
      check("map_timeout", 0, 1);
      m = 0;
    end
    check("writes", nwr, sz * sz);
    tick(1'b0, 8'd0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    #22 rst_n = 1'b1;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_addr", wr_addr, 0);
    // partial map abandoned by an asynchronous reset
    tick(1'b1, 8'd7, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) tick(1'b0, 8'd0, 1'b1, 1'b1, 16'(i + 100));
    #2 rst_n = 1'b0;
    #1;
    check("amid_in_ready", in_ready, 0);
    check("amid_wr_en", wr_en, 0);
    check("amid_busy", busy, 0);
    check("amid_done", done, 0);
    check("amid_wr_addr", wr_addr, 0);
    check("amid_wr_data", wr_data, 0);
    m = 0; sb.delete();
    #3 rst_n = 1'b1;
    run_map(8'd3, 0, 0, 16'hFFFB);
    check("relu_last_data", wr_data, relu(16'hFFFB));
    run_map(8'd7, 0, 0, 16'h0);
    check("basic_last_addr", last_addr, 48);
    run_map(8'd14, 1, 0, 16'h0);
    check("stall_last_addr", last_addr, 195);
    run_map(8'd7, 0, 1, 16'h0);
    run_map(8'd1, 1, 0, 16'h0);
    run_map(8'd0, 0, 0, 16'h0);
    run_map(8'd255, 0, 0, 16'h0);
    check("max_last_addr", last_addr, 65024);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
